// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C subordinate memory slice.
//   i2c_state_t   - protocol FSM state encoding
//   DEV_ADDR_DFLT - default 7-bit device address
//   ADDR_W/DATA_W - memory address / data widths
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEV_ADDR_DFLT = 7'b1100110;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_MEM_ADDR,
    S_MEM_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_regfile.sv
// i2c_regfile: byte array, synchronous write, combinational read,
// synchronous clear of every location on rst.
//   clk, rst      - clock, synchronous active-high reset
//   we/waddr/wdata - write port
//   raddr/rdata    - asynchronous read port
module i2c_regfile
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_top.sv
// i2c_top: I2C subordinate exposing a byte memory.
//   clk            - system clock (>= 8x SCL)
//   rst            - synchronous active-high reset
//   scl, sda       - open-drain I2C lines (driven 0 or Z only)
//   hold_clock_low - request to stretch SCL
// Optional feature macro: I2C_CLOCK_STRETCH_EN enables SCL stretching;
// without it hold_clock_low is ignored and scl is never driven.
// Write: START, addr+W, {mem_addr, mode}, data... ; mode 1 waits for a
// repeated START so the following addr+R reads from the loaded pointer.
module i2c_top
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR  = DEV_ADDR_DFLT,
  parameter int unsigned       MEM_DEPTH = 128
) (
  input  logic clk,
  input  logic rst,
  inout  logic scl,
  inout  logic sda,
  input  logic hold_clock_low
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_c, stop_c;

  i2c_state_t        state, state_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n, rx_byte, rdata;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              dir_bit, dir_n;
  logic              ack_oe, ack_oe_n;
  logic              mem_we, sda_oe, scl_oe;

  // Sync regs reset high so an idle bus produces no spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte  = {shreg[DATA_W-2:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      dir_bit <= 1'b0;
      ack_oe  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      dir_bit <= dir_n;
      ack_oe  <= ack_oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    dir_n     = dir_bit;
    ack_oe_n  = ack_oe;
    mem_we    = 1'b0;
    if (start_c) begin
      state_n   = S_DEV_ADDR;
      bit_cnt_n = '0;
      ack_oe_n  = 1'b0;
    end else if (stop_c) begin
      state_n   = S_IDLE;
      bit_cnt_n = '0;
      ack_oe_n  = 1'b0;
    end else begin
      unique case (state)
        S_DEV_ADDR, S_MEM_ADDR, S_WR_DATA: begin
          if (scl_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              case (state)
                S_DEV_ADDR: begin
                  dir_n   = rx_byte[0];
                  state_n = (rx_byte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_WAIT_STOP;
                end
                S_MEM_ADDR: begin
                  ptr_n   = rx_byte[7:1];
                  dir_n   = rx_byte[0];
                  state_n = S_MEM_ACK;
                end
                default: begin
                  mem_we  = 1'b1;
                  ptr_n   = ptr + 7'd1;
                  state_n = S_WR_ACK;
                end
              endcase
            end
          end
        end
        // bit_cnt 0: waiting for the 8th fall to assert ACK;
        // bit_cnt 1: ACK on the bus, the 9th fall releases it.
        S_DEV_ACK, S_MEM_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              ack_oe_n  = 1'b1;
              bit_cnt_n = 4'd1;
            end else begin
              ack_oe_n  = 1'b0;
              bit_cnt_n = '0;
              case (state)
                S_DEV_ACK: begin
                  if (dir_bit) begin
                    shreg_n = rdata;
                    state_n = S_RD_DATA;
                  end else begin
                    state_n = S_MEM_ADDR;
                  end
                end
                S_MEM_ACK: state_n = dir_bit ? S_WAIT_STOP : S_WR_DATA;
                default:   state_n = S_WR_DATA;
              endcase
            end
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt_n = '0;
              state_n   = S_RD_ACK;
            end else begin
              shreg_n = {shreg[DATA_W-2:0], 1'b0};
            end
          end
        end
        // bit_cnt 1 marks a master ACK; the next fall presents the next byte.
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_n = S_WAIT_STOP;
            end else begin
              ptr_n     = ptr + 7'd1;
              bit_cnt_n = 4'd1;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt_n = '0;
            shreg_n   = rdata;
            state_n   = S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe = ack_oe | ((state == S_RD_DATA) & ~shreg[DATA_W-1]);

`ifdef I2C_CLOCK_STRETCH_EN
  always_ff @(posedge clk) begin
    if (rst || !hold_clock_low) scl_oe <= 1'b0;
    else if (scl_fall)          scl_oe <= 1'b1;
  end
`else
  logic hold_unused;
  assign hold_unused = hold_clock_low;
  assign scl_oe      = 1'b0;
`endif

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl = scl_oe ? 1'b0 : 1'bz;

  i2c_regfile #(
    .DEPTH (MEM_DEPTH)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (ptr),
    .wdata (rx_byte),
    .raddr (ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_i2c_top.sv
// tb_i2c_top: directed bus-level bench for i2c_top acting as I2C master.
module tb_i2c_top;
  import i2c_pkg::*;

  localparam int Q = 80;  // quarter SCL period (8 clk)

  logic clk = 1'b0;
  logic rst;
  logic hold_clock_low;
  logic m_scl_low, m_sda_low;
  logic stretch_seen;
  int   checks   = 0;
  int   failures = 0;
  int unsigned sda_low_cnt = 0;

  wire scl, sda;
  pullup (scl);
  pullup (sda);
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_top #(
    .DEV_ADDR  (7'b1100110),
    .MEM_DEPTH (128)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .scl            (scl),
    .sda            (sda),
    .hold_clock_low (hold_clock_low)
  );

  initial forever #5 clk = ~clk;

  // Counts clocks on which something other than the master pulls sda low.
  always @(negedge clk)
    if (!m_sda_low && sda === 1'b0) sda_low_cnt <= sda_low_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic scl_high();
    m_scl_low = 1'b0;
    for (int i = 0; i < 1000 && scl !== 1'b1; i++) #10;
    if (scl !== 1'b1) check_eq("scl_release_timeout", 32'(scl), 32'd1);
  endtask

  task automatic send_start();
    m_sda_low = 1'b0; #Q;
    scl_high();       #Q;
    m_sda_low = 1'b1; #Q;
    m_scl_low = 1'b1; #Q;
  endtask

  task automatic send_stop();
    m_sda_low = 1'b1; #Q;
    scl_high();       #Q;
    m_sda_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b;   #Q;
    scl_high();       #(2*Q);
    m_scl_low = 1'b1; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #Q;
    scl_high();       #Q;
    b = sda;          #Q;
    m_scl_low = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack_bit);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(mack);
  endtask

  initial begin
    logic        a;
    logic [7:0]  d;
    int unsigned c0;
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    hold_clock_low = 1'b0;
    stretch_seen = 1'b0;
    rst = 1'b1;
    #3;
    #50 rst = 1'b0;
    #50;

    // reset state
    check_eq("rst_state",   32'(dut.state), 32'(S_IDLE));
    check_eq("rst_ptr",     32'(dut.ptr), 32'd0);
    check_eq("rst_bitcnt",  32'(dut.bit_cnt), 32'd0);
    check_eq("rst_sda",     32'(sda), 32'd1);
    check_eq("rst_scl",     32'(scl), 32'd1);
    check_eq("rst_mem0",    32'(dut.u_regfile.mem[0]), 32'h00);
    check_eq("rst_mem127",  32'(dut.u_regfile.mem[127]), 32'h00);

    // write 0x01,0x02 at address 0
    send_start();
    write_byte(8'hCC, a); check_eq("w1_dev_ack", 32'(a), 32'd0);
    write_byte(8'h00, a); check_eq("w1_mem_ack", 32'(a), 32'd0);
    write_byte(8'h01, a); check_eq("w1_d0_ack",  32'(a), 32'd0);
    write_byte(8'h02, a); check_eq("w1_d1_ack",  32'(a), 32'd0);
    send_stop();
    #Q;
    check_eq("w1_mem0",  32'(dut.u_regfile.mem[0]), 32'h01);
    check_eq("w1_mem1",  32'(dut.u_regfile.mem[1]), 32'h02);
    check_eq("w1_ptr",   32'(dut.ptr), 32'd2);
    check_eq("w1_state", 32'(dut.state), 32'(S_IDLE));

    // read from address 1 via repeated START
    send_start();
    write_byte(8'hCC, a); check_eq("r1_dev_ack", 32'(a), 32'd0);
    write_byte(8'h03, a); check_eq("r1_mem_ack", 32'(a), 32'd0);
    send_start();
    write_byte(8'hCD, a); check_eq("r1_rdev_ack", 32'(a), 32'd0);
    read_byte(d, 1'b0);   check_eq("r1_byte0", 32'(d), 32'h02);
    read_byte(d, 1'b1);   check_eq("r1_byte1", 32'(d), 32'h00);
    send_stop();
    #Q;
    check_eq("r1_sda_rel", 32'(sda), 32'd1);
    check_eq("r1_scl_rel", 32'(scl), 32'd1);
    check_eq("r1_state",   32'(dut.state), 32'(S_IDLE));
    check_eq("r1_ptr",     32'(dut.ptr), 32'd2);

    // wrong device address: never driven, no change
    c0 = sda_low_cnt;
    send_start();
    write_byte(8'h4D, a); check_eq("bad_nack", 32'(a), 32'd1);
    send_stop();
    #Q;
    check_eq("bad_sda_drv", sda_low_cnt - c0, 32'd0);
    check_eq("bad_state",   32'(dut.state), 32'(S_IDLE));
    check_eq("bad_mem0",    32'(dut.u_regfile.mem[0]), 32'h01);

    // pointer wrap 127 -> 0
    send_start();
    write_byte(8'hCC, a); check_eq("wr_dev_ack", 32'(a), 32'd0);
    write_byte(8'hFE, a); check_eq("wr_mem_ack", 32'(a), 32'd0);
    write_byte(8'hAA, a); check_eq("wr_d0_ack",  32'(a), 32'd0);
    write_byte(8'h55, a); check_eq("wr_d1_ack",  32'(a), 32'd0);
    send_stop();
    #Q;
    check_eq("wr_mem127", 32'(dut.u_regfile.mem[127]), 32'hAA);
    check_eq("wr_mem0",   32'(dut.u_regfile.mem[0]), 32'h55);
    check_eq("wr_ptr",    32'(dut.ptr), 32'd1);

    // clock stretching request during a data byte (address 5)
    send_start();
    write_byte(8'hCC, a); check_eq("st_dev_ack", 32'(a), 32'd0);
    write_byte(8'h0A, a); check_eq("st_mem_ack", 32'(a), 32'd0);
    hold_clock_low = 1'b1;
    fork
      write_byte(8'h3C, a);
      begin
        for (int i = 0; i < 200 && !stretch_seen; i++) begin
          @(negedge clk);
          if (!m_scl_low && scl === 1'b0) stretch_seen = 1'b1;
        end
        if (stretch_seen) repeat (50) @(negedge clk);
        hold_clock_low = 1'b0;
      end
    join
    check_eq("st_d_ack", 32'(a), 32'd0);
    send_stop();
    #Q;
`ifdef I2C_CLOCK_STRETCH_EN
    check_eq("st_scl_held", 32'(stretch_seen), 32'd1);
`else
    check_eq("st_scl_never_held", 32'(stretch_seen), 32'd0);
`endif
    check_eq("st_mem5", 32'(dut.u_regfile.mem[5]), 32'h3C);

    // reset after 4 bits of a data byte to address 10
    send_start();
    write_byte(8'hCC, a); check_eq("rr_dev_ack", 32'(a), 32'd0);
    write_byte(8'h14, a); check_eq("rr_mem_ack", 32'(a), 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    #20 rst = 1'b0;
    #20;
    check_eq("rr_state",  32'(dut.state), 32'(S_IDLE));
    check_eq("rr_mem10",  32'(dut.u_regfile.mem[10]), 32'h00);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    read_bit(a);          check_eq("rr_ignored_nack", 32'(a), 32'd1);
    send_stop();
    #Q;
    check_eq("rr_mem10_after", 32'(dut.u_regfile.mem[10]), 32'h00);

    send_start();
    write_byte(8'hCC, a); check_eq("rn_dev_ack", 32'(a), 32'd0);
    write_byte(8'h14, a); check_eq("rn_mem_ack", 32'(a), 32'd0);
    write_byte(8'h5A, a); check_eq("rn_d_ack",   32'(a), 32'd0);
    send_stop();
    #Q;
    check_eq("rn_mem10", 32'(dut.u_regfile.mem[10]), 32'h5A);
    send_start();
    write_byte(8'hCC, a); check_eq("rn_rdev_ack", 32'(a), 32'd0);
    write_byte(8'h15, a); check_eq("rn_rmem_ack", 32'(a), 32'd0);
    send_start();
    write_byte(8'hCD, a); check_eq("rn_rd_ack", 32'(a), 32'd0);
    read_byte(d, 1'b1);   check_eq("rn_rd_byte", 32'(d), 32'h5A);
    send_stop();
    #Q;
    check_eq("rn_state", 32'(dut.state), 32'(S_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_top.md
I2C_TOP -- requirements
Module: i2c_top

Interface
REQ-001 Parameter DEV_ADDR, default 7'b1100110, 7-bit subordinate device address.
REQ-002 Parameter MEM_DEPTH, default 128, number of byte locations (7-bit memory address).
REQ-003 clk  input  1  system clock; one clock; all logic on rising edge; clk period at least 8x faster than SCL.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scl  inout  1  I2C clock, open-drain: driven only 0 or Z.
REQ-006 sda  inout  1  I2C data, open-drain: driven only 0 or Z.
REQ-007 hold_clock_low  input  1  user request to stretch SCL.

Function
REQ-008 scl/sda SHALL pass through a 2-FF synchronizer, then edge detection in the clk domain; 2-3 clk latency.
REQ-009 START: sda fall while scl high, from any state, SHALL enter DEV_ADDR and clear the bit counter (repeated START included).
REQ-010 STOP: sda rise while scl high SHALL return to IDLE and release sda/scl.
REQ-011 Bits SHALL be sampled on scl rise, MSB first; sda output SHALL change only after scl fall.
REQ-012 States: IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-013 DEV_ADDR: 7 address bits + R/W; match -> DEV_ACK (drive sda 0 for the 9th clock); mismatch -> WAIT_STOP, no ACK.
REQ-014 After DEV_ACK: R/W=0 -> MEM_ADDR; R/W=1 -> RD_DATA, from the current pointer.
REQ-015 MEM_ADDR byte = 7-bit memory address (MSB first) + mode bit; SHALL load the pointer and ACK; mode 0 -> WR_DATA; mode 1 -> WAIT for repeated START.
REQ-016 WR_DATA: each received byte SHALL be written to mem[pointer] at the 8th scl rise, then ACKed; pointer += 1.
REQ-017 RD_DATA: SHALL drive mem[pointer] MSB first (0 -> drive low, 1 -> Z), then release sda for RD_ACK.
REQ-018 RD_ACK: master ACK (0) -> pointer += 1, next byte; NACK (1) -> WAIT_STOP.
REQ-019 The pointer SHALL wrap 127 -> 0.
REQ-020 A START or STOP inside a byte SHALL abort it; a partial write SHALL NOT be committed.
REQ-021 With stretching enabled, hold_clock_low high SHALL drive scl low after the next scl fall until hold_clock_low is low; the FSM SHALL hold.
REQ-022 When the DUT is not driving, sda and scl SHALL be Z.

Reset
REQ-023 On rst: state IDLE, pointer 0, bit counter 0, sda/scl released (Z), all memory bytes 0x00.
REQ-024 rst asserted mid-transfer SHALL abort; the DUT SHALL ignore the bus until the next START.

Configuration
REQ-025 Macro I2C_CLOCK_STRETCH_EN defined: REQ-021 active.
REQ-026 Macro I2C_CLOCK_STRETCH_EN undefined: hold_clock_low ignored; scl never driven (always Z).

Structure
REQ-027 Package i2c_pkg SHALL hold: state enum typedef, DEV_ADDR default, ADDR_W=7, DATA_W=8.
REQ-028 Sub-module i2c_regfile SHALL be a 128x8 synchronous-write, combinational-read array with synchronous clear on rst; i2c_top holds sync, edge detect, FSM, shifter, pointer.

Verification
REQ-029 START, 0xCC (1100110+W), MEM byte 0x00, data 0x01, 0x02, STOP -> ACK after all four bytes; mem[0]=0x01, mem[1]=0x02.
REQ-030 START, 0xCC, MEM byte 0x03 (addr 1 + read), repeated START, 0xCD, master ACK, then NACK, STOP -> DUT ACKs three bytes; outputs 0x02 then 0x00; bus released.
REQ-031 START, 0x4D (wrong address), STOP -> sda never driven; state IDLE; memory unchanged.
REQ-032 Write to addr 127 with two data bytes 0xAA, 0x55 -> mem[127]=0xAA, mem[0]=0x55.
REQ-033 I2C_CLOCK_STRETCH_EN defined: hold_clock_low=1 during a data byte -> scl held low after the ACK fall until release, then the transfer completes; undefined -> scl stays Z.
REQ-034 rst pulse after the 4th bit of a write byte -> no commit; the next START transfer works normally.
